// File: rtl/tlul_host_arbiter.sv
// Purpose: round-robin share of one TL-UL host adapter port between NUM_HOSTS requesters, with owner tracking for responses.
// Latency: zero-cycle combinational request/grant path; responses are steered to their owner in the cycle they arrive.
// Backpressure: a request ungranted downstream locks its host in place; issue stalls while MAX_OUT transactions are outstanding.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   req_i/gnt_o             per-host request / one-hot grant
//   addr_i/we_i/wdata_i/be_i per-host request fields, host k at slice k
//   valid_o/rdata_o/err_o   one-hot response valid, broadcast data and error
//   dn_*                    single host port towards the adapter
//   outstanding_o           granted-but-unanswered transaction count
//   spurious_o              pulse: response arrived with no recorded owner
module tlul_host_arbiter #(
    parameter int NUM_HOSTS = 2,
    parameter int MAX_OUT   = 2,
    parameter int TL_AW     = 32,
    parameter int TL_DW     = 32,
    parameter int TL_DBW    = TL_DW / 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_HOSTS-1:0]          req_i,
    output logic [NUM_HOSTS-1:0]          gnt_o,
    input  logic [NUM_HOSTS*TL_AW-1:0]    addr_i,
    input  logic [NUM_HOSTS-1:0]          we_i,
    input  logic [NUM_HOSTS*TL_DW-1:0]    wdata_i,
    input  logic [NUM_HOSTS*TL_DBW-1:0]   be_i,
    output logic [NUM_HOSTS-1:0]          valid_o,
    output logic [TL_DW-1:0]              rdata_o,
    output logic                          err_o,
    output logic                          dn_req_o,
    input  logic                          dn_gnt_i,
    output logic [TL_AW-1:0]              dn_addr_o,
    output logic                          dn_we_o,
    output logic [TL_DW-1:0]              dn_wdata_o,
    output logic [TL_DBW-1:0]             dn_be_o,
    input  logic                          dn_valid_i,
    input  logic [TL_DW-1:0]              dn_rdata_i,
    input  logic                          dn_err_i,
    output logic [$clog2(MAX_OUT+1)-1:0]  outstanding_o,
    output logic                          spurious_o
);

    localparam int HW = $clog2(NUM_HOSTS);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    localparam logic [HW:0]   NH_W     = (HW+1)'(NUM_HOSTS);
    localparam logic [HW-1:0] LAST_RST = HW'(NUM_HOSTS - 1);
    localparam logic [PW-1:0] PTR_MAX  = PW'(MAX_OUT - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUT);

    // State
    logic [HW-1:0] last_q, last_d;
    logic          lock_q, lock_d;
    logic [HW-1:0] lock_idx_q, lock_idx_d;
    logic [HW-1:0] owner_q [MAX_OUT];
    logic [HW-1:0] owner_d [MAX_OUT];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Combinational
    logic [HW:0]   cand;
    logic          found;
    logic [HW-1:0] rr_idx;
    logic [HW-1:0] sel;
    logic          full;
    logic          fire;
    logic          pop;

    // Round-robin scan starting just after the last granted host. The sum
    // stays below 2*NUM_HOSTS, so one conditional subtract is the modulo.
    always_comb begin
        rr_idx = last_q;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NUM_HOSTS; i++) begin
            cand = {1'b0, last_q} + (HW+1)'(i);
            if (cand >= NH_W) begin
                cand = cand - NH_W;
            end
            if (!found && req_i[cand[HW-1:0]]) begin
                found  = 1'b1;
                rr_idx = cand[HW-1:0];
            end
        end
    end

    // A presented-but-ungranted request keeps its host until granted.
    assign sel  = lock_q ? lock_idx_q : rr_idx;
    assign full = (count_q == CNT_FULL);

    // Full is judged on the registered count, so a same-cycle pop does not
    // reopen issue until the following cycle.
    assign dn_req_o = ~reset & ~full & (lock_q | (|req_i));
    assign fire     = dn_req_o & dn_gnt_i;
    assign pop      = ~reset & dn_valid_i & (count_q != '0);

    assign spurious_o    = ~reset & dn_valid_i & (count_q == '0);
    assign outstanding_o = reset ? '0 : count_q;
    assign rdata_o       = dn_rdata_i;
    assign err_o         = dn_err_i;

    // Downstream field mux; fields are forced to zero while idle.
    always_comb begin
        dn_addr_o  = '0;
        dn_we_o    = 1'b0;
        dn_wdata_o = '0;
        dn_be_o    = '0;
        for (int h = 0; h < NUM_HOSTS; h++) begin
            if (dn_req_o && (sel == HW'(h))) begin
                dn_addr_o  = addr_i[h*TL_AW +: TL_AW];
                dn_we_o    = we_i[h];
                dn_wdata_o = wdata_i[h*TL_DW +: TL_DW];
                dn_be_o    = be_i[h*TL_DBW +: TL_DBW];
            end
        end
    end

    // Grant and response steering
    always_comb begin
        gnt_o   = '0;
        valid_o = '0;
        for (int h = 0; h < NUM_HOSTS; h++) begin
            gnt_o[h]   = fire && (sel == HW'(h));
            valid_o[h] = pop && (owner_q[rd_ptr_q] == HW'(h));
        end
    end

    // Next-state logic
    always_comb begin
        last_d     = last_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        for (int i = 0; i < MAX_OUT; i++) begin
            owner_d[i] = owner_q[i];
        end

        if (fire) begin
            last_d            = sel;
            lock_d            = 1'b0;
            owner_d[wr_ptr_q] = sel;
            wr_ptr_d          = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);
        end else if (dn_req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);
        end

        case ({fire, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q     <= LAST_RST;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < MAX_OUT; i++) begin
                owner_q[i] <= '0;
            end
        end else begin
            last_q     <= last_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < MAX_OUT; i++) begin
                owner_q[i] <= owner_d[i];
            end
        end
    end

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Purpose: directed bench for tlul_host_arbiter with an owner scoreboard.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled 1 unit later.
// Backpressure: dn_gnt_i is driven per step to exercise lock and full stalls.
module tb_tlul_host_arbiter;

    localparam int NH = 2;
    localparam int MO = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int CW = $clog2(MO + 1);

    localparam logic [AW-1:0] A0 = 32'h0000_1000;
    localparam logic [AW-1:0] A1 = 32'h0000_1004;
    localparam logic [DW-1:0] W0 = 32'hCCCC_0000;
    localparam logic [DW-1:0] W1 = 32'hDDDD_0001;
    localparam logic [BW-1:0] B0 = 4'hF;
    localparam logic [BW-1:0] B1 = 4'h3;

    logic              clock = 1'b0;
    logic              reset;
    logic [NH-1:0]     req_i;
    logic [NH-1:0]     gnt_o;
    logic [NH*AW-1:0]  addr_i;
    logic [NH-1:0]     we_i;
    logic [NH*DW-1:0]  wdata_i;
    logic [NH*BW-1:0]  be_i;
    logic [NH-1:0]     valid_o;
    logic [DW-1:0]     rdata_o;
    logic              err_o;
    logic              dn_req_o;
    logic              dn_gnt_i;
    logic [AW-1:0]     dn_addr_o;
    logic              dn_we_o;
    logic [DW-1:0]     dn_wdata_o;
    logic [BW-1:0]     dn_be_o;
    logic              dn_valid_i;
    logic [DW-1:0]     dn_rdata_i;
    logic              dn_err_i;
    logic [CW-1:0]     outstanding_o;
    logic              spurious_o;

    int n_chk  = 0;
    int n_pass = 0;
    int sb[$];

    always #5 clock = ~clock;

    tlul_host_arbiter #(
        .NUM_HOSTS (NH),
        .MAX_OUT   (MO),
        .TL_AW     (AW),
        .TL_DW     (DW),
        .TL_DBW    (BW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_i         (req_i),
        .gnt_o         (gnt_o),
        .addr_i        (addr_i),
        .we_i          (we_i),
        .wdata_i       (wdata_i),
        .be_i          (be_i),
        .valid_o       (valid_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .dn_req_o      (dn_req_o),
        .dn_gnt_i      (dn_gnt_i),
        .dn_addr_o     (dn_addr_o),
        .dn_we_o       (dn_we_o),
        .dn_wdata_o    (dn_wdata_o),
        .dn_be_o       (dn_be_o),
        .dn_valid_i    (dn_valid_i),
        .dn_rdata_i    (dn_rdata_i),
        .dn_err_i      (dn_err_i),
        .outstanding_o (outstanding_o),
        .spurious_o    (spurious_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [AW-1:0] host_addr(input int h);
        case (h)
            0:       return A0;
            1:       return A1;
            default: return '0;
        endcase
    endfunction

    function automatic logic [DW-1:0] host_wdata(input int h);
        case (h)
            0:       return W0;
            1:       return W1;
            default: return '0;
        endcase
    endfunction

    function automatic logic [BW-1:0] host_be(input int h);
        case (h)
            0:       return B0;
            1:       return B1;
            default: return '0;
        endcase
    endfunction

    // One clock cycle: drive inputs, check outputs against the expected
    // downstream host (-1 = no request) and the owner scoreboard, advance.
    task automatic step(input logic [NH-1:0] req, input logic gnt, input logic vld,
                        input logic [DW-1:0] rd, input logic er,
                        input int exp_host, input string tag);
        logic [NH-1:0] exp_gnt;
        logic [NH-1:0] exp_vld;
        int            owner;
        req_i      = req;
        dn_gnt_i   = gnt;
        dn_valid_i = vld;
        dn_rdata_i = rd;
        dn_err_i   = er;
        #1;
        exp_gnt = (gnt && exp_host >= 0) ? NH'(1 << exp_host) : '0;
        chk({tag, "/outstanding"}, 64'(outstanding_o), 64'(sb.size()));
        chk({tag, "/dn_req"},      64'(dn_req_o),      64'(exp_host >= 0));
        chk({tag, "/gnt"},         64'(gnt_o),         64'(exp_gnt));
        chk({tag, "/dn_addr"},     64'(dn_addr_o),     64'(host_addr(exp_host)));
        chk({tag, "/dn_we"},       64'(dn_we_o),       64'(exp_host == 1));
        chk({tag, "/dn_wdata"},    64'(dn_wdata_o),    64'(host_wdata(exp_host)));
        chk({tag, "/dn_be"},       64'(dn_be_o),       64'(host_be(exp_host)));
        if (vld && !reset && sb.size() > 0) begin
            owner   = sb.pop_front();
            exp_vld = NH'(1 << owner);
            chk({tag, "/valid"},    64'(valid_o),    64'(exp_vld));
            chk({tag, "/rdata"},    64'(rdata_o),    64'(rd));
            chk({tag, "/err"},      64'(err_o),      64'(er));
            chk({tag, "/spurious"}, 64'(spurious_o), 64'(0));
        end else if (vld && !reset) begin
            chk({tag, "/valid"},    64'(valid_o),    64'(0));
            chk({tag, "/spurious"}, 64'(spurious_o), 64'(1));
        end else begin
            chk({tag, "/valid"},    64'(valid_o),    64'(0));
            chk({tag, "/spurious"}, 64'(spurious_o), 64'(0));
        end
        if (exp_gnt != '0) begin
            sb.push_back(exp_host);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        req_i      = '0;
        dn_gnt_i   = 1'b0;
        dn_valid_i = 1'b0;
        dn_rdata_i = '0;
        dn_err_i   = 1'b0;
        addr_i     = {A1, A0};
        we_i       = 2'b10;
        wdata_i    = {W1, W0};
        be_i       = {B1, B0};
        @(posedge clock);
        #1;

        // Reset: everything quiet even with requests, grant and response present
        step(2'b11, 1'b1, 1'b1, 32'h1234_5678, 1'b1, -1, "rst0");
        step(2'b11, 1'b1, 1'b0, 32'h0,         1'b0, -1, "rst1");
        reset = 1'b0;

        // Fairness: alternating grants, one-cycle responses
        step(2'b11, 1'b1, 1'b0, 32'h0,         1'b0,  0, "fair0");
        step(2'b11, 1'b1, 1'b1, 32'h0000_0F00, 1'b0,  1, "fair1");
        step(2'b11, 1'b1, 1'b1, 32'h0000_0F01, 1'b0,  0, "fair2");
        step(2'b11, 1'b1, 1'b1, 32'h0000_0F02, 1'b0,  1, "fair3");
        step(2'b00, 1'b0, 1'b1, 32'h0000_0F03, 1'b0, -1, "fair4");

        // Lock: host1 held against a later host0 request until granted
        step(2'b10, 1'b0, 1'b0, 32'h0, 1'b0,  1, "lock0");
        step(2'b11, 1'b0, 1'b0, 32'h0, 1'b0,  1, "lock1");
        step(2'b11, 1'b0, 1'b0, 32'h0, 1'b0,  1, "lock2");
        step(2'b11, 1'b1, 1'b0, 32'h0, 1'b0,  1, "lock3");
        step(2'b01, 1'b1, 1'b0, 32'h0, 1'b0,  0, "lock4");
        step(2'b00, 1'b0, 1'b1, 32'h0000_0A01, 1'b0, -1, "lock5");
        step(2'b00, 1'b0, 1'b1, 32'h0000_0A02, 1'b0, -1, "lock6");

        // Full: two outstanding blocks issue; a pop reopens issue next cycle
        step(2'b11, 1'b1, 1'b0, 32'h0, 1'b0,  1, "full0");
        step(2'b11, 1'b1, 1'b0, 32'h0, 1'b0,  0, "full1");
        step(2'b11, 1'b1, 1'b0, 32'h0, 1'b0, -1, "full2");
        step(2'b11, 1'b1, 1'b1, 32'h0000_0B01, 1'b0, -1, "full3");
        step(2'b11, 1'b1, 1'b0, 32'h0, 1'b0,  1, "full4");
        step(2'b00, 1'b0, 1'b1, 32'h0000_0B02, 1'b0, -1, "full5");
        step(2'b00, 1'b0, 1'b1, 32'h0000_0B03, 1'b0, -1, "full6");

        // Routing: data and error follow the owner in issue order
        step(2'b01, 1'b1, 1'b0, 32'h0,         1'b0,  0, "route0");
        step(2'b10, 1'b1, 1'b0, 32'h0,         1'b0,  1, "route1");
        step(2'b00, 1'b0, 1'b1, 32'hAAAA_0000, 1'b0, -1, "route2");
        step(2'b00, 1'b0, 1'b1, 32'h5555_1111, 1'b1, -1, "route3");

        // Spurious response with nothing outstanding
        step(2'b00, 1'b0, 1'b1, 32'h0000_0C01, 1'b0, -1, "spur0");
        step(2'b00, 1'b0, 1'b0, 32'h0,         1'b0, -1, "spur1");

        // Reset mid-operation: one outstanding and host1 locked
        step(2'b01, 1'b1, 1'b0, 32'h0, 1'b0,  0, "mid0");
        step(2'b10, 1'b0, 1'b0, 32'h0, 1'b0,  1, "mid1");
        reset = 1'b1;
        sb.delete();
        step(2'b11, 1'b1, 1'b0, 32'h0, 1'b0, -1, "mid2");
        reset = 1'b0;
        step(2'b00, 1'b0, 1'b1, 32'h0000_0D01, 1'b0, -1, "mid3");
        step(2'b11, 1'b1, 1'b0, 32'h0,         1'b0,  0, "mid4");
        step(2'b00, 1'b0, 1'b1, 32'h0000_0D02, 1'b0, -1, "mid5");

        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
